// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-fetch port and a data-memory port onto one shared
// memory port, with round-robin tie-break, one outstanding access and an ack timeout.
module mem_arbiter #(
    parameter logic [15:0] TIMEOUT_CYC = 16'd255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_rdata_o,
    output logic        if_ack_o,
    input  logic        dm_req_i,
    input  logic        dm_we_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_wdata_i,
    output logic [31:0] dm_rdata_o,
    output logic        dm_ack_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i,
    output logic        stall_o,
    output logic        err_o
);

    typedef enum logic [1:0] {IDLE, IF_ACC, DM_ACC} state_t;

    state_t      state;
    logic        last_dm;
    logic [15:0] wait_cnt;

    logic timeout_hit;
    logic done;
    logic grant_dm;
    logic grant_if;

    // A real ack in the limit cycle wins over the timeout.
    assign timeout_hit = (TIMEOUT_CYC != 16'd0) && (wait_cnt == TIMEOUT_CYC) && !mem_ack_i;
    assign done        = mem_ack_i | timeout_hit;

    // Contention goes to the requester that did not win last time.
    assign grant_dm = start_i & dm_req_i & (~if_req_i | ~last_dm);
    assign grant_if = start_i & if_req_i & (~dm_req_i | last_dm);

    assign if_ack_o   = rst_i & (state == IF_ACC) & done;
    assign dm_ack_o   = rst_i & (state == DM_ACC) & done;
    assign if_rdata_o = (rst_i && state == IF_ACC && mem_ack_i) ? mem_rdata_i : 32'h0;
    assign dm_rdata_o = (rst_i && state == DM_ACC && mem_ack_i) ? mem_rdata_i : 32'h0;

    assign stall_o = (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o);

    // Arbitration FSM with registered shared-port outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= 32'h0;
            mem_wdata_o <= 32'h0;
            last_dm     <= 1'b0;
            wait_cnt    <= 16'h0;
            err_o       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_dm) begin
                        state       <= DM_ACC;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= dm_we_i;
                        mem_addr_o  <= dm_addr_i;
                        mem_wdata_o <= dm_wdata_i;
                        last_dm     <= 1'b1;
                        wait_cnt    <= 16'h0;
                    end else if (grant_if) begin
                        state       <= IF_ACC;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= 1'b0;
                        mem_addr_o  <= if_addr_i;
                        mem_wdata_o <= 32'h0;
                        last_dm     <= 1'b0;
                        wait_cnt    <= 16'h0;
                    end
                end
                IF_ACC, DM_ACC: begin
                    if (done) begin
                        state     <= IDLE;
                        mem_req_o <= 1'b0;
                        mem_we_o  <= 1'b0;
                        if (timeout_hit) begin
                            err_o <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    mem_req_o <= 1'b0;
                    mem_we_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 16'd255, max cycles a granted access waits for mem_ack_i; 0 disables the timeout.
REQ-002 clk_i  input  1  clock; all state updates on rising edge.
REQ-003 rst_i  input  1  synchronous, active-low reset.
REQ-004 start_i  input  1  run enable; low blocks new grants.
REQ-005 if_req_i  input  1  instruction-fetch request; held with if_addr_i stable until if_ack_o.
REQ-006 if_addr_i  input  32  fetch byte address.
REQ-007 if_rdata_o  output  32  fetch read data, valid with if_ack_o.
REQ-008 if_ack_o  output  1  fetch completion, 1-cycle pulse.
REQ-009 dm_req_i  input  1  data-memory request; held with dm_we_i/dm_addr_i/dm_wdata_i stable until dm_ack_o.
REQ-010 dm_we_i  input  1  1 = store, 0 = load.
REQ-011 dm_addr_i  input  32  data byte address.
REQ-012 dm_wdata_i  input  32  store data.
REQ-013 dm_rdata_o  output  32  load data, valid with dm_ack_o.
REQ-014 dm_ack_o  output  1  data completion, 1-cycle pulse.
REQ-015 mem_req_o  output  1  shared memory port request, registered.
REQ-016 mem_we_o  output  1  shared port write enable, registered.
REQ-017 mem_addr_o  output  32  shared port address, registered.
REQ-018 mem_wdata_o  output  32  shared port write data, registered.
REQ-019 mem_rdata_i  input  32  shared port read data, valid with mem_ack_i.
REQ-020 mem_ack_i  input  1  shared port completion.
REQ-021 stall_o  output  1  pipeline stall: a requester is pending and not acked this cycle.
REQ-022 err_o  output  1  sticky timeout flag.

Function
REQ-023 FSM states IDLE, IF_ACC, DM_ACC; exactly one access outstanding on the shared port at any time.
REQ-024 IDLE, start_i=1: dm_req_i only -> DM_ACC; if_req_i only -> IF_ACC; both -> DM_ACC unless last_dm=1, then IF_ACC; neither or start_i=0 -> stay IDLE.
REQ-025 On grant edge, mem_req_o=1 and mem_addr_o/mem_we_o/mem_wdata_o loaded from the winner (IF: we=0, wdata=0); held constant until the access ends.
REQ-026 last_dm register set to 1 on DM grant, 0 on IF grant.
REQ-027 In IF_ACC/DM_ACC, mem_ack_i=1: matching ack_o=1 combinationally that cycle, matching rdata_o=mem_rdata_i; next edge -> IDLE, mem_req_o=0, mem_we_o=0.
REQ-028 ack_o and rdata_o of the non-granted requester stay 0; both outputs 0 in IDLE.
REQ-029 Latency: req sampled at edge t, mem_req_o high after t; earliest ack cycle t+1; one IDLE cycle between consecutive accesses.
REQ-030 start_i falling during an access: access completes normally; no new grant until start_i=1.
REQ-031 Wait counter (16 bit) cleared on grant, +1 each ACC cycle without mem_ack_i.
REQ-032 Counter reaching TIMEOUT_CYC (TIMEOUT_CYC != 0) without ack: matching ack_o=1 with rdata_o=32'h0 that cycle, err_o set, next edge -> IDLE with mem_req_o=0.
REQ-033 mem_ack_i in the timeout cycle takes precedence: normal completion, err_o unchanged.
REQ-034 err_o cleared only by reset.
REQ-035 mem_ack_i in IDLE is ignored.
REQ-036 stall_o = (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o), combinational.

Reset
REQ-037 rst_i=0 at an edge: state IDLE, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, last_dm=0, counter=0, err_o=0.
REQ-038 Reset mid-access abandons it; no ack_o issued; while rst_i=0, ack_o/rdata_o=0 and stall_o follows REQ-036.

Verification
REQ-039 Fetch: if_req_i=1, addr 0x40; mem_ack_i after 2 cycles with rdata 0x8C010004 -> mem_addr_o=0x40, we=0, if_ack_o 1-cycle pulse, if_rdata_o=0x8C010004, stall_o low only in ack cycle.
REQ-040 Contention: if_req_i and dm_req_i (store 0x10, data 0xA5A5A5A5) rise together from reset -> DM granted first (mem_we_o=1), IF granted next after one IDLE cycle.
REQ-041 Fairness: dm_req_i held continuously with back-to-back accesses, if_req_i pending -> grants alternate DM, IF, DM.
REQ-042 Timeout: TIMEOUT_CYC=4, mem_ack_i never asserted -> ack_o pulse with rdata 0 after 4 wait cycles, err_o=1 sticky, mem_req_o low next cycle.
REQ-043 Reset mid-access: rst_i=0 during DM_ACC -> next edge mem_req_o=0, no dm_ack_o; after release, held dm_req_i is regranted.
REQ-044 start_i=0 with both requests pending -> no mem_req_o, stall_o=1; start_i=1 -> DM granted next edge.
